flatten_stream_buffer: RTL and testbench

//  Collects NUM_CH feature-map channels of FRAME_LEN words each from the conv/pool stream

---
 rtl/flatten_stream_buffer.sv | 116 +++++++++++
 tb/tb_flatten_stream_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flatten_stream_buffer.sv
// rtl/flatten_stream_buffer.sv - collects NUM_CH x FRAME_LEN stream words into one flat frame for the FC stage
// Optional macro FLATTEN_OVF_CNT_EN adds o_ovf_count (saturating count of valid words presented while FULL).
module flatten_stream_buffer #(
    parameter int DATA_W    = 22,
    parameter int NUM_CH    = 1,
    parameter int FRAME_LEN = 225,
    parameter int ORDER     = 0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    i_data_valid,
    output logic                                    o_data_ready,
    input  logic signed [DATA_W-1:0]                i_data_in,
    input  logic                                    i_frame_ack,
    input  logic                                    i_clear,
    output logic                                    o_buffer_full,
    output logic signed [DATA_W-1:0]                o_flattened_data [0:NUM_CH*FRAME_LEN-1],
    output logic [$clog2(NUM_CH*FRAME_LEN+1)-1:0]   o_fill_count
`ifdef FLATTEN_OVF_CNT_EN
    ,
    output logic [15:0]                             o_ovf_count
`endif
);

    localparam int DEPTH  = NUM_CH * FRAME_LEN;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int POS_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic {FILL, FULL} state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_count;
    logic                     r_full;
    logic                     r_ready;
    logic signed [DATA_W-1:0] r_data [0:DEPTH-1];
    logic [ADDR_W-1:0]        w_addr;
    logic                     w_write;
    logic                     w_rearm;

    assign w_write = (r_state == FILL) && i_data_valid && !i_clear;
    assign w_rearm = i_clear || ((r_state == FULL) && i_frame_ack);

    generate
        if (ORDER == 1) begin : g_transpose
            // Arrival is channel-fastest; scatter each word into its channel-major slot.
            logic [CH_W-1:0]  r_ch;
            logic [POS_W-1:0] r_pos;

            always_ff @(posedge clk) begin
                if (!rst || w_rearm) begin
                    r_ch  <= '0;
                    r_pos <= '0;
                end else if (w_write) begin
                    if (r_ch == CH_W'(NUM_CH - 1)) begin
                        r_ch  <= '0;
                        r_pos <= (r_pos == POS_W'(FRAME_LEN - 1)) ? '0 : r_pos + 1'b1;
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
            end

            assign w_addr = ADDR_W'(r_ch) * ADDR_W'(FRAME_LEN) + ADDR_W'(r_pos);
        end else begin : g_linear
            assign w_addr = ADDR_W'(r_count);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= FILL;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ready <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (w_rearm) begin
            // Data array is kept; the next frame overwrites it in place.
            r_state <= FILL;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ready <= 1'b1;
        end else if (w_write) begin
            r_data[w_addr] <= i_data_in;
            r_count        <= r_count + 1'b1;
            if (r_count == CNT_W'(DEPTH - 1)) begin
                r_state <= FULL;
                r_full  <= 1'b1;
                r_ready <= 1'b0;
            end
        end
    end

    assign o_data_ready     = r_ready;
    assign o_buffer_full    = r_full;
    assign o_fill_count     = r_count;
    assign o_flattened_data = r_data;

`ifdef FLATTEN_OVF_CNT_EN
    logic [15:0] r_ovf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= '0;
        end else if ((r_state == FULL) && i_data_valid && (r_ovf != 16'hFFFF)) begin
            r_ovf <= r_ovf + 16'd1;
        end
    end

    assign o_ovf_count = r_ovf;
`endif

endmodule

// File: tb/tb_flatten_stream_buffer.sv
// tb/tb_flatten_stream_buffer.sv - scoreboard bench for flatten_stream_buffer (default and transposed builds)
module tb_flatten_stream_buffer;

    localparam int DW = 22;
    localparam int D1 = 225;
    localparam int D2 = 12;

    typedef struct {
        int                   addr;
        logic signed [DW-1:0] val;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic                 v1, ack1, clr1;
    logic signed [DW-1:0] d1;
    logic                 rdy1, full1;
    logic signed [DW-1:0] flat1 [0:D1-1];
    logic [7:0]           cnt1;
`ifdef FLATTEN_OVF_CNT_EN
    logic [15:0]          ovf1, ovf2;
`endif

    logic                 v2, ack2, clr2;
    logic signed [DW-1:0] d2;
    logic                 rdy2, full2;
    logic signed [DW-1:0] flat2 [0:D2-1];
    logic [3:0]           cnt2;

    flatten_stream_buffer dut1 (
        .clk(clk), .rst(rst),
        .i_data_valid(v1), .o_data_ready(rdy1), .i_data_in(d1),
        .i_frame_ack(ack1), .i_clear(clr1), .o_buffer_full(full1),
        .o_flattened_data(flat1), .o_fill_count(cnt1)
`ifdef FLATTEN_OVF_CNT_EN
        , .o_ovf_count(ovf1)
`endif
    );

    flatten_stream_buffer #(.DATA_W(DW), .NUM_CH(3), .FRAME_LEN(4), .ORDER(1)) dut2 (
        .clk(clk), .rst(rst),
        .i_data_valid(v2), .o_data_ready(rdy2), .i_data_in(d2),
        .i_frame_ack(ack2), .i_clear(clr2), .o_buffer_full(full2),
        .o_flattened_data(flat2), .o_fill_count(cnt2)
`ifdef FLATTEN_OVF_CNT_EN
        , .o_ovf_count(ovf2)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;
    int mc1      = 0;
    exp_t sb1[$];
    exp_t sb2[$];
    logic signed [DW-1:0] m1 [0:D1-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill1(input int n, input int kind);
        logic signed [DW-1:0] val;
        for (int i = 0; i < n; i++) begin
            case (kind)
                0:       val = DW'(mc1 + 1);
                1:       val = -22'sd1;
                default: val = DW'(mc1 * 37 - 4000);
            endcase
            v1 = 1'b1;
            d1 = val;
            sb1.push_back('{mc1, val});
            m1[mc1] = val;
            mc1++;
            tick();
        end
        v1 = 1'b0;
    endtask

    task automatic drain1(input string tag);
        exp_t e;
        while (sb1.size() > 0) begin
            e = sb1.pop_front();
            n_assert++;
            if (flat1[e.addr] !== e.val) begin
                n_fail++;
                $display("FAIL %s data[%0d]: got %0d expected %0d", tag, e.addr, flat1[e.addr], e.val);
            end
        end
    endtask

    task automatic ack_frame(input string tag);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        mc1 = 0;
        n_assert++;
        if (full1 !== 1'b0 || rdy1 !== 1'b1 || cnt1 !== 8'd0) begin
            n_fail++;
            $display("FAIL %s: full/ready/count got %b/%b/%0d expected 0/1/0", tag, full1, rdy1, cnt1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; v1 = 0; ack1 = 0; clr1 = 0; d1 = '0;
        v2 = 0; ack2 = 0; clr2 = 0; d2 = '0;
        tick(); tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < D1; i++) m1[i] = '0;
        n_assert++;
        if (full1 !== 1'b0 || rdy1 !== 1'b1 || cnt1 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: full/ready/count got %b/%b/%0d expected 0/1/0", full1, rdy1, cnt1);
        end
        n_assert++;
        if (flat1[0] !== '0 || flat1[D1-1] !== '0 || flat2[0] !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %0d/%0d/%0d expected 0/0/0", flat1[0], flat1[D1-1], flat2[0]);
        end
        n_assert++;
        if (full2 !== 1'b0 || rdy2 !== 1'b1 || cnt2 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_dut2: full/ready/count got %b/%b/%0d expected 0/1/0", full2, rdy2, cnt2);
        end
`ifdef FLATTEN_OVF_CNT_EN
        n_assert++;
        if (ovf1 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %0d expected 0", ovf1);
        end
`endif
    endtask

    task automatic test_fill();
        fill1(D1 - 1, 0);
        n_assert++;
        if (full1 !== 1'b0 || rdy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_early_full: full/ready got %b/%b expected 0/1", full1, rdy1);
        end
        fill1(1, 0);
        n_assert++;
        if (full1 !== 1'b1 || rdy1 !== 1'b0 || cnt1 !== 8'd225) begin
            n_fail++;
            $display("FAIL fill_full: full/ready/count got %b/%b/%0d expected 1/0/225", full1, rdy1, cnt1);
        end
        n_assert++;
        if (flat1[0] !== 22'sd1 || flat1[D1-1] !== 22'sd225) begin
            n_fail++;
            $display("FAIL fill_ends: data[0]/data[224] got %0d/%0d expected 1/225", flat1[0], flat1[D1-1]);
        end
        drain1("fill");
    endtask

    task automatic test_overflow();
        int bad;
        v1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d1 = DW'(9000 + i);
            tick();
        end
        v1 = 1'b0;
        bad = 0;
        for (int i = 0; i < D1; i++) if (flat1[i] !== m1[i]) bad++;
        n_assert++;
        if (bad != 0 || full1 !== 1'b1 || cnt1 !== 8'd225) begin
            n_fail++;
            $display("FAIL overflow_hold: changed words %0d full %b count %0d expected 0/1/225", bad, full1, cnt1);
        end
`ifdef FLATTEN_OVF_CNT_EN
        n_assert++;
        if (ovf1 !== 16'd5) begin
            n_fail++;
            $display("FAIL overflow_count: got %0d expected 5", ovf1);
        end
`endif
    endtask

    task automatic test_transpose();
        int tbl [0:D2-1];
        int ch, pos;
        exp_t e;
        tbl = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
        ch = 0; pos = 0;
        for (int k = 0; k < D2; k++) begin
            v2 = 1'b1;
            d2 = DW'(k);
            sb2.push_back('{ch * 4 + pos, DW'(k)});
            if (ch == 2) begin ch = 0; pos++; end else ch++;
            tick();
        end
        v2 = 1'b0;
        n_assert++;
        if (full2 !== 1'b1 || cnt2 !== 4'd12 || rdy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL transpose_full: full/count/ready got %b/%0d/%b expected 1/12/0", full2, cnt2, rdy2);
        end
        while (sb2.size() > 0) begin
            e = sb2.pop_front();
            n_assert++;
            if (flat2[e.addr] !== e.val) begin
                n_fail++;
                $display("FAIL transpose data[%0d]: got %0d expected %0d", e.addr, flat2[e.addr], e.val);
            end
        end
        for (int i = 0; i < D2; i++) begin
            n_assert++;
            if (flat2[i] !== DW'(tbl[i])) begin
                n_fail++;
                $display("FAIL transpose_tbl[%0d]: got %0d expected %0d", i, flat2[i], tbl[i]);
            end
        end
    endtask

    task automatic test_frame_ack();
        ack_frame("ack_rearm");
        fill1(10, 1);
        ack1 = 1'b1;
        fill1(1, 1);
        ack1 = 1'b0;
        n_assert++;
        if (cnt1 !== 8'd11) begin
            n_fail++;
            $display("FAIL ack_in_fill: count got %0d expected 11", cnt1);
        end
        fill1(D1 - 11, 1);
        n_assert++;
        if (full1 !== 1'b1 || cnt1 !== 8'd225) begin
            n_fail++;
            $display("FAIL ack_refill: full/count got %b/%0d expected 1/225", full1, cnt1);
        end
        drain1("ack_frame");
`ifdef FLATTEN_OVF_CNT_EN
        n_assert++;
        if (ovf1 !== 16'd5) begin
            n_fail++;
            $display("FAIL ack_ovf_kept: got %0d expected 5", ovf1);
        end
`endif
    endtask

    task automatic test_clear();
        int bad;
        ack_frame("clear_rearm");
        fill1(100, 2);
        n_assert++;
        if (cnt1 !== 8'd100) begin
            n_fail++;
            $display("FAIL clear_pre: count got %0d expected 100", cnt1);
        end
        v1 = 1'b1; d1 = 22'sd7777; clr1 = 1'b1;
        tick();
        v1 = 1'b0; clr1 = 1'b0;
        sb1.delete();
        mc1 = 0;
        n_assert++;
        if (cnt1 !== 8'd0 || full1 !== 1'b0 || rdy1 !== 1'b1 || flat1[100] !== m1[100]) begin
            n_fail++;
            $display("FAIL clear_drop: count/full/ready/data[100] got %0d/%b/%b/%0d expected 0/0/1/%0d",
                     cnt1, full1, rdy1, flat1[100], m1[100]);
        end
        fill1(D1, 0);
        n_assert++;
        if (full1 !== 1'b1 || cnt1 !== 8'd225) begin
            n_fail++;
            $display("FAIL clear_refill: full/count got %b/%0d expected 1/225", full1, cnt1);
        end
        drain1("clear");
        bad = 0;
        for (int i = 0; i < D1; i++) if (flat1[i] !== m1[i]) bad++;
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL clear_array: mismatched words got %0d expected 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        int bad;
        ack_frame("reset_rearm");
        fill1(50, 2);
        n_assert++;
        if (cnt1 !== 8'd50) begin
            n_fail++;
            $display("FAIL midreset_pre: count got %0d expected 50", cnt1);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sb1.delete();
        mc1 = 0;
        bad = 0;
        for (int i = 0; i < D1; i++) if (flat1[i] !== '0) bad++;
        n_assert++;
        if (bad != 0 || cnt1 !== 8'd0 || full1 !== 1'b0 || rdy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset: nonzero words/count/full/ready got %0d/%0d/%b/%b expected 0/0/0/1",
                     bad, cnt1, full1, rdy1);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_transpose();
        test_frame_ack();
        test_clear();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
